riscv_rf_wb_ctrl: RTL and testbench

RISCV_RF_WB_CTRL -- requirements
Module: riscv_rf_wb_ctrl

---
 rtl/riscv_rf_wb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_riscv_rf_wb_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wb_ctrl.sv
// Register-file write-back controller: ALU results on port A, MC results and the LSU queue on port B.
// Optional performance counters are enabled by defining RISCV_WB_PERF_CNT_EN.
module riscv_rf_wb_ctrl #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  mc_valid_i,
   input  logic [ADDR_WIDTH-1:0] mc_waddr_i,
   input  logic [DATA_WIDTH-1:0] mc_wdata_i,
   input  logic                  lsu_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_ready_o,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   output logic                  we_b_o,
   output logic                  lsu_pending_o
`ifdef RISCV_WB_PERF_CNT_EN
   ,
   output logic [31:0]           wb_cnt_o,
   output logic [31:0]           drop_cnt_o
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic alu_take;
   logic mc_take;
   logic push;
   logic pop;
   logic drop;

   logic                  mc_vld;
   logic [ADDR_WIDTH-1:0] mc_addr;
   logic [DATA_WIDTH-1:0] mc_data;

   entry_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic               full_q;
   logic               head_valid;
   entry_t             head;

   logic [ADDR_WIDTH-1:0] hold_addr_b;
   logic [DATA_WIDTH-1:0] hold_data_b;
   logic [ADDR_WIDTH-1:0] cand_addr;
   logic [DATA_WIDTH-1:0] cand_data;

   // x0 writes are filtered here so they never reach any storage
   assign alu_take = alu_valid_i && (alu_waddr_i != '0);
   assign mc_take  = mc_valid_i  && (mc_waddr_i  != '0);
   assign push     = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != '0);

   assign lsu_ready_o   = ~full_q;
   assign head_valid    = (count != '0);
   assign lsu_pending_o = head_valid;
   assign head          = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_a_o    <= 1'b0;
         waddr_a_o <= '0;
         wdata_a_o <= '0;
      end else begin
         we_a_o <= alu_take;
         if (alu_take) begin
            waddr_a_o <= alu_waddr_i;
            wdata_a_o <= alu_wdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc_vld  <= 1'b0;
         mc_addr <= '0;
         mc_data <= '0;
      end else begin
         mc_vld <= mc_take;
         if (mc_take) begin
            mc_addr <= mc_waddr_i;
            mc_data <= mc_wdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{addr: lsu_waddr_i, data: lsu_wdata_i};
      end
   end

   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count  <= count_next;
         full_q <= (count_next == CNT_W'(FIFO_DEPTH));
      end
   end

   // MC owns port B whenever it is present; a head matching a performed MC write is stale and popped
   always_comb begin
      we_b_o    = 1'b0;
      pop       = 1'b0;
      drop      = 1'b0;
      cand_addr = hold_addr_b;
      cand_data = hold_data_b;
      if (mc_vld) begin
         if (we_a_o && (mc_addr == waddr_a_o)) begin
            drop = 1'b1;
         end else begin
            we_b_o    = 1'b1;
            cand_addr = mc_addr;
            cand_data = mc_data;
            if (head_valid && (head.addr == mc_addr)) begin
               pop  = 1'b1;
               drop = 1'b1;
            end
         end
      end else if (head_valid) begin
         pop = 1'b1;
         if (we_a_o && (head.addr == waddr_a_o)) begin
            drop = 1'b1;
         end else begin
            we_b_o    = 1'b1;
            cand_addr = head.addr;
            cand_data = head.data;
         end
      end
   end

   always_comb begin
      waddr_b_o = cand_addr;
      wdata_b_o = cand_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_addr_b <= '0;
         hold_data_b <= '0;
      end else if (we_b_o) begin
         hold_addr_b <= cand_addr;
         hold_data_b <= cand_data;
      end
   end

`ifdef RISCV_WB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_cnt_o   <= '0;
         drop_cnt_o <= '0;
      end else begin
         wb_cnt_o   <= wb_cnt_o + 32'(we_a_o) + 32'(we_b_o);
         drop_cnt_o <= drop_cnt_o + 32'(drop);
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_riscv_rf_wb_ctrl.sv
// Self-checking bench for riscv_rf_wb_ctrl: directed vector table, corner sequences, random vs queue model.
// Counter checks are compiled in when RISCV_WB_PERF_CNT_EN is defined.
module tb_riscv_rf_wb_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_waddr = '0;
   logic [DW-1:0] alu_wdata = '0;
   logic          mc_valid = 1'b0;
   logic [AW-1:0] mc_waddr = '0;
   logic [DW-1:0] mc_wdata = '0;
   logic          lsu_valid = 1'b0;
   logic [AW-1:0] lsu_waddr = '0;
   logic [DW-1:0] lsu_wdata = '0;
   logic          lsu_ready;
   logic [AW-1:0] waddr_a;
   logic [DW-1:0] wdata_a;
   logic          we_a;
   logic [AW-1:0] waddr_b;
   logic [DW-1:0] wdata_b;
   logic          we_b;
   logic          lsu_pending;
`ifdef RISCV_WB_PERF_CNT_EN
   logic [31:0]   wb_cnt;
   logic [31:0]   drop_cnt;
`endif

   riscv_rf_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid_i(alu_valid), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
      .mc_valid_i(mc_valid), .mc_waddr_i(mc_waddr), .mc_wdata_i(mc_wdata),
      .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
      .lsu_ready_o(lsu_ready),
      .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
      .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
      .lsu_pending_o(lsu_pending)
`ifdef RISCV_WB_PERF_CNT_EN
      , .wb_cnt_o(wb_cnt), .drop_cnt_o(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          alu_v;
      logic [AW-1:0] alu_a;
      logic [DW-1:0] alu_d;
      logic          mc_v;
      logic [AW-1:0] mc_a;
      logic [DW-1:0] mc_d;
      logic          lsu_v;
      logic [AW-1:0] lsu_a;
      logic [DW-1:0] lsu_d;
   } in_t;

   typedef struct {
      in_t           in;
      logic          we_a;
      logic [AW-1:0] wa;
      logic [DW-1:0] da;
      logic          we_b;
      logic [AW-1:0] wb;
      logic [DW-1:0] db;
      logic          rdy;
      logic          pend;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   int unsigned total = 0;
   int unsigned bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input logic ewa, input logic [AW-1:0] ea,
                          input logic [DW-1:0] ed, input logic ewb, input logic [AW-1:0] eb,
                          input logic [DW-1:0] edb, input logic erdy, input logic epend);
      chk({tag, ".we_a"}, 32'(we_a), 32'(ewa));
      chk({tag, ".waddr_a"}, 32'(waddr_a), 32'(ea));
      chk({tag, ".wdata_a"}, wdata_a, ed);
      chk({tag, ".we_b"}, 32'(we_b), 32'(ewb));
      chk({tag, ".waddr_b"}, 32'(waddr_b), 32'(eb));
      chk({tag, ".wdata_b"}, wdata_b, edb);
      chk({tag, ".ready"}, 32'(lsu_ready), 32'(erdy));
      chk({tag, ".pending"}, 32'(lsu_pending), 32'(epend));
   endtask

   function automatic in_t mk_in(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                                 input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
      in_t r;
      r.alu_v = av; r.alu_a = aa; r.alu_d = ad;
      r.mc_v = mv;  r.mc_a = ma;  r.mc_d = md;
      r.lsu_v = lv; r.lsu_a = la; r.lsu_d = ld;
      return r;
   endfunction

   function automatic vec_t mk_vec(input in_t i, input logic ewa, input logic [AW-1:0] ea,
                                   input logic [DW-1:0] ed, input logic ewb, input logic [AW-1:0] eb,
                                   input logic [DW-1:0] edb, input logic erdy, input logic epend);
      vec_t v;
      v.in = i; v.we_a = ewa; v.wa = ea; v.da = ed;
      v.we_b = ewb; v.wb = eb; v.db = edb; v.rdy = erdy; v.pend = epend;
      return v;
   endfunction

   task automatic drive(input in_t i);
      alu_valid = i.alu_v; alu_waddr = i.alu_a; alu_wdata = i.alu_d;
      mc_valid  = i.mc_v;  mc_waddr  = i.mc_a;  mc_wdata  = i.mc_d;
      lsu_valid = i.lsu_v; lsu_waddr = i.lsu_a; lsu_wdata = i.lsu_d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(mk_in(0, '0, '0, 0, '0, '0, 0, '0, '0));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: a queue for the LSU backlog, one MC slot, the last port-A write
   logic          m_we_a;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_da;
   logic          m_mc_v;
   logic [AW-1:0] m_mc_a;
   logic [DW-1:0] m_mc_d;
   ent_t          mq[$];
   logic [AW-1:0] m_hb_a;
   logic [DW-1:0] m_hb_d;
   logic [31:0]   m_wbc;
   logic [31:0]   m_drc;
   logic          e_we_b;
   logic [AW-1:0] e_wb;
   logic [DW-1:0] e_db;
   logic          e_pop;
   logic          e_drop;

   task automatic model_reset();
      m_we_a = 0; m_wa = '0; m_da = '0;
      m_mc_v = 0; m_mc_a = '0; m_mc_d = '0;
      mq.delete();
      m_hb_a = '0; m_hb_d = '0; m_wbc = '0; m_drc = '0;
   endtask

   task automatic model_expect();
      e_we_b = 0; e_wb = m_hb_a; e_db = m_hb_d; e_pop = 0; e_drop = 0;
      if (m_mc_v) begin
         if (m_we_a && m_mc_a == m_wa) e_drop = 1;
         else begin
            e_we_b = 1; e_wb = m_mc_a; e_db = m_mc_d;
            if (mq.size() > 0 && mq[0].addr == m_mc_a) begin e_pop = 1; e_drop = 1; end
         end
      end else if (mq.size() > 0) begin
         e_pop = 1;
         if (m_we_a && mq[0].addr == m_wa) e_drop = 1;
         else begin e_we_b = 1; e_wb = mq[0].addr; e_db = mq[0].data; end
      end
   endtask

   task automatic model_advance(input in_t i);
      ent_t e;
      bit   rdy;
      m_wbc = m_wbc + 32'(m_we_a) + 32'(e_we_b);
      m_drc = m_drc + 32'(e_drop);
      if (e_we_b) begin m_hb_a = e_wb; m_hb_d = e_db; end
      rdy = (mq.size() < DEPTH);
      if (e_pop) void'(mq.pop_front());
      if (i.lsu_v && rdy && i.lsu_a != 0) begin e.addr = i.lsu_a; e.data = i.lsu_d; mq.push_back(e); end
      m_mc_v = i.mc_v && (i.mc_a != 0);
      if (m_mc_v) begin m_mc_a = i.mc_a; m_mc_d = i.mc_d; end
      if (i.alu_v && i.alu_a != 0) begin m_we_a = 1; m_wa = i.alu_a; m_da = i.alu_d; end
      else m_we_a = 0;
   endtask

   vec_t vecs[$];
   in_t  idle;

   initial begin
      int unsigned acc;
      int unsigned nxt;
      bit          low_seen;
      ent_t        got[$];
      ent_t        accq[$];
      ent_t        e;
      in_t         ri;

      idle = mk_in(0, '0, '0, 0, '0, '0, 0, '0, '0);

      // Directed vectors from reset; expected outputs are those seen one cycle after the inputs
      vecs.push_back(mk_vec(mk_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0), 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(idle,                                      0, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(mk_in(1, 7, 32'h1, 0, 0, 0, 1, 7, 32'h2),  1, 7, 32'h1, 0, 0, 0, 1, 1));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 32'h55),     0, 7, 32'h1, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 3, 32'h33),     0, 7, 32'h1, 1, 3, 32'h33, 1, 1));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 0, 3, 32'h33, 1, 0));
      vecs.push_back(mk_vec(mk_in(0, 0, 0, 1, 9, 32'h99, 1, 9, 32'h88), 0, 7, 32'h1, 1, 9, 32'h99, 1, 1));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 0, 9, 32'h99, 1, 0));
      vecs.push_back(mk_vec(mk_in(0, 0, 0, 1, 4, 32'h44, 1, 6, 32'h66), 0, 7, 32'h1, 1, 4, 32'h44, 1, 1));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 1, 6, 32'h66, 1, 1));
      vecs.push_back(mk_vec(idle,                                      0, 7, 32'h1, 0, 6, 32'h66, 1, 0));

      // Reset values, observed while reset is held
      #1;
      cmp_all("reset", 0, '0, '0, 0, '0, '0, 1, 0);
      do_reset();
      foreach (vecs[k]) begin
         drive(vecs[k].in);
         @(negedge clk);
         cmp_all($sformatf("vec%0d", k), vecs[k].we_a, vecs[k].wa, vecs[k].da,
                 vecs[k].we_b, vecs[k].wb, vecs[k].db, vecs[k].rdy, vecs[k].pend);
      end

      // Continuous MC for 6 cycles with LSU offered every cycle: backpressure then in-order drain
      do_reset();
      acc = 0; low_seen = 0; got.delete();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (we_b) begin e.addr = waddr_b; e.data = wdata_b; got.push_back(e); end
         ri = idle;
         if (c < 6) begin
            ri.mc_v = 1; ri.mc_a = AW'(10 + c); ri.mc_d = 32'hA0 + 32'(c);
            ri.lsu_v = 1; ri.lsu_a = AW'(acc + 1); ri.lsu_d = 32'hB0 + 32'(acc + 1);
            if (lsu_ready) acc++;
            else if (!low_seen) begin
               low_seen = 1;
               chk("ready_low_after", acc, 4);
            end
         end
         drive(ri);
      end
      chk("ready_low_seen", 32'(low_seen), 1);
      chk("bp_accepted", acc, 4);
      chk("bp_writes", got.size(), 10);
      for (int k = 0; k < 10; k++) begin
         if (k < got.size()) begin
            chk($sformatf("bp_addr%0d", k), 32'(got[k].addr), (k < 6) ? 32'(10 + k) : 32'(k - 5));
            chk($sformatf("bp_data%0d", k), got[k].data, (k < 6) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - 5));
         end
      end

      // Mid-operation reset discards queued entries
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ri = idle;
         ri.mc_v = 1; ri.mc_a = AW'(20 + c); ri.mc_d = 32'(c);
         if (c < 3) begin ri.lsu_v = 1; ri.lsu_a = AW'(c + 1); ri.lsu_d = 32'(c + 100); end
         drive(ri);
      end
      @(negedge clk);
      chk("pre_rst_pending", 32'(lsu_pending), 1);
      drive(idle);
      rst_n = 1'b0;
      #1;
      cmp_all("mid_rst", 0, '0, '0, 0, '0, '0, 1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst_we_b%0d", c), 32'(we_b), 0);
         chk($sformatf("post_rst_pend%0d", c), 32'(lsu_pending), 0);
      end

      // Ten entries through a depth-4 queue, MC stalling every third cycle
      do_reset();
      nxt = 1; got.delete(); accq.delete();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (we_b && waddr_b <= 10) begin e.addr = waddr_b; e.data = wdata_b; got.push_back(e); end
         ri = idle;
         if (c % 3 == 0 && c < 30) begin ri.mc_v = 1; ri.mc_a = AW'(20 + c % 8); ri.mc_d = 32'(c); end
         if (nxt <= 10) begin
            ri.lsu_v = 1; ri.lsu_a = AW'(nxt); ri.lsu_d = 32'h100 + 32'(nxt);
            if (lsu_ready) begin e.addr = ri.lsu_a; e.data = ri.lsu_d; accq.push_back(e); nxt++; end
         end
         drive(ri);
      end
      chk("wrap_count", got.size(), accq.size());
      chk("wrap_accepted", accq.size(), 10);
      for (int k = 0; k < 10; k++) begin
         if (k < got.size() && k < accq.size()) begin
            chk($sformatf("wrap_addr%0d", k), 32'(got[k].addr), 32'(accq[k].addr));
            chk($sformatf("wrap_data%0d", k), got[k].data, accq[k].data);
         end
      end

      // Randomised traffic against the queue model, small address range to force collisions
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         model_expect();
         cmp_all($sformatf("rnd%0d", c), m_we_a, m_wa, m_da, e_we_b, e_wb, e_db,
                 (mq.size() < DEPTH), (mq.size() != 0));
`ifdef RISCV_WB_PERF_CNT_EN
         chk($sformatf("rnd%0d.wb_cnt", c), wb_cnt, m_wbc);
         chk($sformatf("rnd%0d.drop_cnt", c), drop_cnt, m_drc);
`endif
         ri.alu_v = ($urandom % 2) == 0;
         ri.alu_a = AW'($urandom_range(0, 7));
         ri.alu_d = $urandom;
         ri.mc_v  = ($urandom % 3) == 0;
         ri.mc_a  = AW'($urandom_range(0, 7));
         ri.mc_d  = $urandom;
         ri.lsu_v = ($urandom % 4) != 0;
         ri.lsu_a = AW'($urandom_range(0, 7));
         ri.lsu_d = $urandom;
         drive(ri);
         model_advance(ri);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
